// File: rtl/mfp_param_digit_display.sv
// rtl/mfp_param_digit_display.sv - multiplexed hex digit display driver with PWM dimming
// Scans one digit per prescaler period; inputs are sampled once per frame so a frame never tears.
module mfp_param_digit_display #(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_LOG2 = 14,
  parameter int BRIGHT_W     = 4
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [4*N_DIGITS-1:0]   number,
  input  logic [N_DIGITS-1:0]     dots,
  input  logic [N_DIGITS-1:0]     digit_en,
  input  logic                    blank_lz,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [6:0]              seven_segments,
  output logic                    dot,
  output logic [N_DIGITS-1:0]     anodes,
  output logic                    frame_start
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  logic [REFRESH_LOG2-1:0] prescaler;
  logic [IDX_W-1:0]        index;

  logic [4*N_DIGITS-1:0]   sh_number;
  logic [N_DIGITS-1:0]     sh_dots;
  logic [N_DIGITS-1:0]     sh_en;
  logic                    sh_blank;
  logic [BRIGHT_W-1:0]     sh_bright;

  logic                    frame_cycle;
  logic [4*N_DIGITS-1:0]   eff_number;
  logic [N_DIGITS-1:0]     eff_dots;
  logic [N_DIGITS-1:0]     eff_en;
  logic                    eff_blank;
  logic [BRIGHT_W-1:0]     eff_bright;

  logic [3:0]              cur_nibble;
  logic                    cur_dot;
  logic                    cur_en;
  logic                    nonzero_hi;
  logic                    blanked;
  logic                    pwm_on;
  logic                    lit;
  logic [N_DIGITS-1:0]     anodes_next;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  assign frame_cycle = (prescaler == '0) && (index == '0);

  // The first slot of a frame is decided in the same cycle the shadows load,
  // so it must see the values being captured rather than the stale shadows.
  assign eff_number = frame_cycle ? number     : sh_number;
  assign eff_dots   = frame_cycle ? dots       : sh_dots;
  assign eff_en     = frame_cycle ? digit_en   : sh_en;
  assign eff_blank  = frame_cycle ? blank_lz   : sh_blank;
  assign eff_bright = frame_cycle ? brightness : sh_bright;

  always_comb begin
    cur_nibble = 4'h0;
    cur_dot    = 1'b0;
    cur_en     = 1'b0;
    nonzero_hi = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (IDX_W'(i) == index) begin
        cur_nibble = eff_number[4*i +: 4];
        cur_dot    = eff_dots[i];
        cur_en     = eff_en[i];
      end
      if ((IDX_W'(i) >= index) && (eff_number[4*i +: 4] != 4'h0)) nonzero_hi = 1'b1;
    end
  end

  assign blanked = eff_blank && (index != '0) && !nonzero_hi;
  assign pwm_on  = prescaler[REFRESH_LOG2-1 -: BRIGHT_W] <= eff_bright;
  assign lit     = cur_en && !blanked && pwm_on;

  always_comb begin
    anodes_next = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (lit && (IDX_W'(i) == index)) anodes_next[i] = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      prescaler      <= '0;
      index          <= '0;
      sh_number      <= '0;
      sh_dots        <= '0;
      sh_en          <= '0;
      sh_blank       <= 1'b0;
      sh_bright      <= '0;
      seven_segments <= 7'h7F;
      dot            <= 1'b1;
      anodes         <= '1;
      frame_start    <= 1'b0;
    end else begin
      prescaler <= prescaler + REFRESH_LOG2'(1);
      if (prescaler == '1) index <= (index == LAST_IDX) ? '0 : index + IDX_W'(1);
      if (frame_cycle) begin
        sh_number <= number;
        sh_dots   <= dots;
        sh_en     <= digit_en;
        sh_blank  <= blank_lz;
        sh_bright <= brightness;
      end
      seven_segments <= lit ? hex_to_seg(cur_nibble) : 7'h7F;
      dot            <= lit ? ~cur_dot : 1'b1;
      anodes         <= anodes_next;
      frame_start    <= frame_cycle;
    end
  end

endmodule

// File: tb/tb_mfp_param_digit_display.sv
// tb/tb_mfp_param_digit_display.sv - scoreboard bench for mfp_param_digit_display
// Reference model works from cycle count since reset; monitor pops one expectation per cycle.
module tb_mfp_param_digit_display;

  localparam int N  = 4;
  localparam int RL = 4;
  localparam int BW = 2;
  localparam int SLOT  = 1 << RL;
  localparam int FRAME = SLOT * N;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic [15:0]   number = '0;
  logic [3:0]    dots = '0;
  logic [3:0]    digit_en = '0;
  logic          blank_lz = 1'b0;
  logic [1:0]    brightness = '0;
  logic [6:0]    seven_segments;
  logic          dot;
  logic [3:0]    anodes;
  logic          frame_start;

  mfp_param_digit_display #(
    .N_DIGITS(N), .REFRESH_LOG2(RL), .BRIGHT_W(BW)
  ) dut (
    .clock(clock), .resetn(resetn), .number(number), .dots(dots),
    .digit_en(digit_en), .blank_lz(blank_lz), .brightness(brightness),
    .seven_segments(seven_segments), .dot(dot), .anodes(anodes),
    .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       fs;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_inactive(input string name);
    chk({name, "_an"}, 32'(anodes), 32'hF);
    chk({name, "_seg"}, 32'(seven_segments), 32'h7F);
    chk({name, "_dot"}, 32'(dot), 32'h1);
    chk({name, "_fs"}, 32'(frame_start), 32'h0);
  endtask

  // Reference model: position in the scan comes straight from elapsed cycles.
  int          k = 0;
  logic [15:0] sh_num = '0;
  logic [3:0]  sh_dots = '0;
  logic [3:0]  sh_en = '0;
  logic        sh_blk = 1'b0;
  logic [1:0]  sh_br = '0;

  always @(posedge clock) begin : model
    exp_t        e;
    logic [15:0] n;
    logic [3:0]  d;
    logic [3:0]  en;
    logic        b;
    logic [1:0]  br;
    int          p;
    int          idx;
    bit          blanked;
    bit          lit;
    if (!resetn) begin
      k <= 0;
    end else begin
      if (k % FRAME == 0) begin
        n = number; d = dots; en = digit_en; b = blank_lz; br = brightness;
        sh_num <= number; sh_dots <= dots; sh_en <= digit_en;
        sh_blk <= blank_lz; sh_br <= brightness;
      end else begin
        n = sh_num; d = sh_dots; en = sh_en; b = sh_blk; br = sh_br;
      end
      p   = k % SLOT;
      idx = (k / SLOT) % N;
      blanked = b && (idx > 0) && ((n >> (4 * idx)) == 16'h0);
      lit = en[idx] && !blanked && ((p / (SLOT >> BW)) <= int'(br));
      e.an  = lit ? ~(4'b0001 << idx) : 4'hF;
      e.seg = lit ? seg_tab[n[4*idx +: 4]] : 7'h7F;
      e.dp  = lit ? ~d[idx] : 1'b1;
      e.fs  = (k % FRAME == 0);
      sb.push_back(e);
      k <= k + 1;
    end
  end

  always @(negedge clock) begin : monitor
    exp_t e;
    if (!resetn) begin
      check_inactive("reset_hold");
    end else if (sb.size() == 0) begin
      chk("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk("anodes", 32'(anodes), 32'(e.an));
      chk("segments", 32'(seven_segments), 32'(e.seg));
      chk("dot", 32'(dot), 32'(e.dp));
      chk("frame_start", 32'(frame_start), 32'(e.fs));
    end
    chk("one_anode_max", 32'($countones(~anodes) <= 1), 32'd1);
  end

  task automatic set_in(input logic [15:0] num, input logic [3:0] dp, input logic [3:0] en,
                        input logic blk, input logic [1:0] br);
    @(negedge clock);
    #1;
    number = num; dots = dp; digit_en = en; blank_lz = blk; brightness = br;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clock);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    #1;
    number = 16'h12AF; dots = 4'h0; digit_en = 4'hF; blank_lz = 1'b0; brightness = 2'd3;
    resetn = 1'b1;
    run(2 * FRAME);

    set_in(16'h0050, 4'h0, 4'hF, 1'b1, 2'd3);  run(2 * FRAME);
    set_in(16'h0000, 4'h0, 4'hF, 1'b1, 2'd3);  run(2 * FRAME);
    set_in(16'h8421, 4'hF, 4'hF, 1'b0, 2'd0);  run(2 * FRAME);
    set_in(16'hC3D9, 4'h5, 4'hF, 1'b0, 2'd2);  run(2 * FRAME);
    set_in(16'h1111, 4'h0, 4'hF, 1'b0, 2'd3);  run(FRAME + 20);
    set_in(16'h2222, 4'h0, 4'hF, 1'b0, 2'd3);  run(2 * FRAME);
    set_in(16'h7B6E, 4'b0100, 4'b1011, 1'b0, 2'd3);  run(2 * FRAME);

    // Asynchronous reset in the middle of a slot.
    run(FRAME + 7);
    #2;
    resetn = 1'b0;
    sb.delete();
    #1;
    check_inactive("async_reset");
    repeat (2) @(negedge clock);
    #1;
    resetn = 1'b1;
    run(2 * FRAME);

    repeat (3000) begin
      @(negedge clock);
      #1;
      if ($urandom_range(19) == 0) begin
        number     = 16'($urandom);
        if ($urandom_range(3) == 0) number = number & 16'h00FF;
        dots       = 4'($urandom);
        digit_en   = 4'($urandom);
        blank_lz   = 1'($urandom);
        brightness = 2'($urandom);
      end
    end
    run(4);
    @(negedge clock);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mfp_param_digit_display.md
MFP_PARAM_DIGIT_DISPLAY -- requirements
Module: mfp_param_digit_display

Interface
REQ-001 Parameter N_DIGITS, default 8: number of multiplexed digits, range 1..16.
REQ-002 Parameter REFRESH_LOG2, default 14: log2 of clocks per digit slot; SHALL be >= BRIGHT_W.
REQ-003 Parameter BRIGHT_W, default 4: brightness control width.
REQ-004 clock  input  1  single clock; all state on its rising edge.
REQ-005 resetn  input  1  reset, asynchronous, active-low.
REQ-006 number  input  4*N_DIGITS  hex nibbles; nibble i = digit i, digit 0 rightmost.
REQ-007 dots  input  N_DIGITS  per-digit decimal point request, active-high.
REQ-008 digit_en  input  N_DIGITS  per-digit enable, active-high.
REQ-009 blank_lz  input  1  leading-zero blanking enable.
REQ-010 brightness  input  BRIGHT_W  PWM duty code; all ones = full on.
REQ-011 seven_segments  output  7  {g,f,e,d,c,b,a}, active-low, registered.
REQ-012 dot  output  1  decimal point, active-low, registered.
REQ-013 anodes  output  N_DIGITS  digit select, active-low, one-hot-low or all high, registered.
REQ-014 frame_start  output  1  one-cycle pulse at each frame-start cycle, registered.

Function
REQ-015 Prescaler: REFRESH_LOG2-bit counter, increments every cycle, wraps to 0 after all ones.
REQ-016 Digit index: advances by 1 when prescaler wraps; N_DIGITS-1 wraps to 0.
REQ-017 Frame-start cycle: prescaler == 0 and index == 0, including first cycle after reset release.
REQ-018 On frame-start cycle: shadow registers capture number, dots, digit_en, blank_lz, brightness; all display decisions for the frame use shadow values only (no tearing mid-frame).
REQ-019 Leading-zero blanking (shadow blank_lz=1): digit i (i>0) blanked when its nibble and all higher nibbles are 0; digit 0 never blanked.
REQ-020 Digit lit in slot when digit_en[i]=1, not blanked, and PWM on.
REQ-021 PWM on when top BRIGHT_W bits of prescaler <= shadow brightness; brightness 0 = 1/2^BRIGHT_W duty, all ones = 100%.
REQ-022 Lit digit: anodes bit i = 0, all others 1; seven_segments = hex decode of nibble i; dot = ~dots[i].
REQ-023 Unlit digit: anodes all 1, seven_segments 7'h7F, dot 1.
REQ-024 Hex decode, active-low {g..a}: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
REQ-025 Latency: outputs reflect counter state of the previous cycle (exactly one register stage); frame_start high the cycle after frame-start cycle.
REQ-026 Never more than one anode low in any cycle, including digit transitions.
REQ-027 Input changes mid-frame SHALL NOT affect outputs until next frame-start capture.

Reset
REQ-028 resetn low: asynchronously prescaler=0, index=0, shadows=0, anodes all 1, seven_segments 7'h7F, dot 1, frame_start 0.
REQ-029 Reset asserted mid-frame: all outputs inactive immediately, no glitch low on any anode.
REQ-030 After release, scan restarts at digit 0 with fresh shadow capture on first clock.

Verification (N_DIGITS=4, REFRESH_LOG2=4, BRIGHT_W=2 unless noted)
REQ-031 number=16'h12AF, digit_en=F, brightness=3, blank_lz=0 -> anodes E,D,B,7 each 16 cycles; segments 0E,08,24,79; frame_start every 64 cycles.
REQ-032 number=16'h0050, blank_lz=1 -> digits 3,2 anodes stay high; digit 1 shows 12, digit 0 shows 40; number=0 -> only digit 0 lit showing 40.
REQ-033 brightness=0 -> each digit anode low 4 of 16 cycles; brightness=2 -> 12 of 16.
REQ-034 number changed mid-frame from 16'h1111 to 16'h2222 -> remaining slots still show 79; 24 appears only after next frame_start.
REQ-035 dots=4'b0100, digit_en=4'b1011 -> digit 2 dark including dot; dot low never asserted; other digits normal.
REQ-036 resetn pulsed low mid-slot -> outputs inactive same cycle asynchronously; after release, digit 0 lit first, frame_start one cycle after first clock.
